// File: rtl/led_pulse_stretcher_pkg.sv
// Board-wide LED/UI constants shared by the pulse stretcher and its channels.
package led_pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOn   = 2'd1,
    StGap  = 2'd2
  } led_state_e;

  // Defaults for a 100 MHz clock: 20 ms on, 10 ms mandatory dark gap.
  localparam int unsigned DefaultOnCycles  = 2_000_000;
  localparam int unsigned DefaultOffCycles = 1_000_000;
  localparam int unsigned DefaultCntW      = 21;

endpackage

// File: rtl/led_stretch_chan.sv
// One LED channel: edge detect, ON/GAP sequencing with a single-deep pending event.
module led_stretch_chan
  import led_pulse_stretcher_pkg::*;
#(
  parameter int unsigned OnCycles  = DefaultOnCycles,
  parameter int unsigned OffCycles = DefaultOffCycles,
  parameter int unsigned CntW      = DefaultCntW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic evt,
  output logic led,
  output logic busy,
  output logic pending
);

  localparam logic [CntW-1:0] OnLast  = CntW'(OnCycles - 1);
  localparam logic [CntW-1:0] OffLast = CntW'((OffCycles == 0) ? 0 : OffCycles - 1);

  led_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic            evt_q;
  logic            led_q, busy_q;
  logic            trig;

  assign trig = evt & ~evt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    unique case (state_q)
      StIdle: begin
        if (trig) begin
          state_d = StOn;
          cnt_d   = '0;
        end
      end
      StOn: begin
        if (trig) begin
          cnt_d = '0;
        end else if (cnt_q == OnLast) begin
          state_d = (OffCycles == 0) ? StIdle : StGap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == OffLast) begin
          state_d = (pend_q || trig) ? StOn : StIdle;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (trig) pend_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // evt_q keeps tracking evt through reset so a level held across reset is not a new edge.
    evt_q <= evt;
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      led_q   <= (state_d == StOn);
      busy_q  <= (state_d != StIdle);
    end
  end

  assign led     = led_q;
  assign busy    = busy_q;
  assign pending = pend_q;

endmodule

// File: rtl/led_pulse_stretcher.sv
// Widens short internal events into visible LED pulses, one independent channel per bit.
module led_pulse_stretcher
  import led_pulse_stretcher_pkg::*;
#(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned ON_CYCLES  = DefaultOnCycles,
  parameter int unsigned OFF_CYCLES = DefaultOffCycles,
  parameter int unsigned CNT_W      = DefaultCntW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] evt,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] pending
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    led_stretch_chan #(
      .OnCycles  (ON_CYCLES),
      .OffCycles (OFF_CYCLES),
      .CntW      (CNT_W)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .evt     (evt[i]),
      .led     (led[i]),
      .busy    (busy[i]),
      .pending (pending[i])
    );
  end

endmodule
